weight_stream_receiver: RTL and testbench

//  Receiving end of the layer-serial weight stream (valid/layer/addr/data) that main_net emits on
//  o_weight_* and that loaders drive into i_weight_*. Captures a full network weight set into three
//  per-layer RAMs, enforces strict stream order, flags protocol violations, and reports load-done.

---
 rtl/weight_stream_pkg.sv | 32 +++
 rtl/weight_stream_receiver_if.sv | 42 ++++
 rtl/weight_ram.sv | 33 +++
 rtl/weight_stream_receiver.sv | 225 ++++++++++++++++++++++
 tb/tb_weight_stream_receiver.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_stream_pkg.sv
// Shared definitions for the weight stream receiver: default geometry,
// derived per-layer word counts, layer codes and the load FSM state type.
package weight_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH           = 32;
  localparam int unsigned DEF_LAYER_WIDTH          = 2;
  localparam int unsigned DEF_WEIGHT_COUNTER_WIDTH = 11;
  localparam int unsigned DEF_INPUT_NODES          = 2;
  localparam int unsigned DEF_HIDDEN1_NODES        = 32;
  localparam int unsigned DEF_HIDDEN2_NODES        = 32;
  localparam int unsigned DEF_OUTPUT_NODES         = 3;

  // Words per layer: one weight per fan-in plus one bias per node.
  localparam int unsigned N1 = DEF_HIDDEN1_NODES * (DEF_INPUT_NODES + 1);
  localparam int unsigned N2 = DEF_HIDDEN2_NODES * (DEF_HIDDEN1_NODES + 1);
  localparam int unsigned N3 = DEF_OUTPUT_NODES * (DEF_HIDDEN2_NODES + 1);

  localparam logic [DEF_LAYER_WIDTH-1:0] LAYER_NONE = 2'b00;
  localparam logic [DEF_LAYER_WIDTH-1:0] LAYER_H1   = 2'b01;
  localparam logic [DEF_LAYER_WIDTH-1:0] LAYER_H2   = 2'b10;
  localparam logic [DEF_LAYER_WIDTH-1:0] LAYER_OUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_H1  = 3'd1,
    ST_RX_H2  = 3'd2,
    ST_RX_OUT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/weight_stream_receiver_if.sv
// Bundle of the weight stream, control and readback signals around the
// receiver. master = loader/host side, slave = receiver side.
//  i_weight_valid/layer/addr/i_weight : incoming stream word
//  i_clear                            : abort/restart
//  i_rd_en/layer/addr                 : readback request
//  o_rd_valid/o_rd_data               : readback response (latency 1)
//  o_busy/o_load_done/o_error         : load status
interface weight_stream_receiver_if
  import weight_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int unsigned LAYER_WIDTH          = DEF_LAYER_WIDTH,
  parameter int unsigned WEIGHT_COUNTER_WIDTH = DEF_WEIGHT_COUNTER_WIDTH
);

  logic                            i_weight_valid;
  logic [LAYER_WIDTH-1:0]          i_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr;
  logic [DATA_WIDTH-1:0]           i_weight;
  logic                            i_clear;
  logic                            i_rd_en;
  logic [LAYER_WIDTH-1:0]          i_rd_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] i_rd_addr;
  logic                            o_rd_valid;
  logic [DATA_WIDTH-1:0]           o_rd_data;
  logic                            o_busy;
  logic                            o_load_done;
  logic                            o_error;

  modport master (
    output i_weight_valid, i_weight_layer, i_weight_addr, i_weight, i_clear,
    output i_rd_en, i_rd_layer, i_rd_addr,
    input  o_rd_valid, o_rd_data, o_busy, o_load_done, o_error
  );

  modport slave (
    input  i_weight_valid, i_weight_layer, i_weight_addr, i_weight, i_clear,
    input  i_rd_en, i_rd_layer, i_rd_addr,
    output o_rd_valid, o_rd_data, o_busy, o_load_done, o_error
  );

endinterface

// File: rtl/weight_ram.sv
// Simple dual-port weight RAM: one synchronous write port, one registered
// read port. A read and write to the same word in one cycle returns the
// old contents. Contents are not reset.
//  clk          : clock
//  we/waddr/wdata : write port
//  re/raddr     : read request, rdata updates the following cycle
module weight_ram #(
  parameter  int unsigned DEPTH = 96,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; nonblocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_stream_receiver.sv
// Receiving end of the layer-serial weight stream. Captures a full network
// weight set into three per-layer RAMs, enforces strict in-order delivery,
// flags protocol violations (sticky until i_clear) and reports load-done.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : stream input, clear, readback port and status outputs
module weight_stream_receiver
  import weight_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                    = DEF_DATA_WIDTH,
  parameter int unsigned LAYER_WIDTH                   = DEF_LAYER_WIDTH,
  parameter int unsigned WEIGHT_COUNTER_WIDTH          = DEF_WEIGHT_COUNTER_WIDTH,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = DEF_INPUT_NODES,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = DEF_HIDDEN1_NODES,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = DEF_HIDDEN2_NODES,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = DEF_OUTPUT_NODES
) (
  input logic                    clk,
  input logic                    rst_n,
  weight_stream_receiver_if.slave bus
);

  localparam int unsigned AW = WEIGHT_COUNTER_WIDTH;
  localparam int unsigned LW = LAYER_WIDTH;

  localparam int unsigned SIZE_H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int unsigned SIZE_H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int unsigned SIZE_OUT = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

  localparam int unsigned AW_H1  = (SIZE_H1 > 1)  ? $clog2(SIZE_H1)  : 1;
  localparam int unsigned AW_H2  = (SIZE_H2 > 1)  ? $clog2(SIZE_H2)  : 1;
  localparam int unsigned AW_OUT = (SIZE_OUT > 1) ? $clog2(SIZE_OUT) : 1;

  localparam logic [AW-1:0] LAST_H1  = AW'(SIZE_H1 - 1);
  localparam logic [AW-1:0] LAST_H2  = AW'(SIZE_H2 - 1);
  localparam logic [AW-1:0] LAST_OUT = AW'(SIZE_OUT - 1);

  localparam logic [LW-1:0] L_NONE = LW'(LAYER_NONE);
  localparam logic [LW-1:0] L_H1   = LW'(LAYER_H1);
  localparam logic [LW-1:0] L_H2   = LW'(LAYER_H2);
  localparam logic [LW-1:0] L_OUT  = LW'(LAYER_OUT);

  state_t          state, state_n;
  logic [AW-1:0]   exp_addr, exp_addr_n;
  logic            busy_q, done_q, error_q;
  logic            busy_n, done_n, error_n;
  logic            we_h1_c, we_h2_c, we_out_c;
  logic            addr_match_c;
  logic            first_word_c;

  logic            rd_valid_q;
  logic [LW-1:0]   rd_sel_q;
  logic            rd_hit_h1_c, rd_hit_h2_c, rd_hit_out_c;
  logic [DATA_WIDTH-1:0] rdata_h1, rdata_h2, rdata_out;
  logic [DATA_WIDTH-1:0] rd_data_c;

  assign addr_match_c = (bus.i_weight_addr == exp_addr);
  assign first_word_c = (bus.i_weight_layer == L_H1) && (bus.i_weight_addr == '0);

  // Load FSM state and expected-address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      exp_addr <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      exp_addr <= exp_addr_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  // Next state, RAM write enables and next status flags. Any word that is
  // not exactly the next expected (layer, addr) sends the FSM to ERR
  // without being written; i_clear overrides everything.
  always_comb begin
    state_n    = state;
    exp_addr_n = exp_addr;
    we_h1_c    = 1'b0;
    we_h2_c    = 1'b0;
    we_out_c   = 1'b0;

    if (bus.i_clear) begin
      state_n    = ST_IDLE;
      exp_addr_n = '0;
    end else if (bus.i_weight_valid) begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (first_word_c) begin
            we_h1_c    = 1'b1;
            state_n    = ST_RX_H1;
            exp_addr_n = AW'(1);
          end else begin
            state_n = ST_ERR;
          end
        end
        ST_RX_H1: begin
          if ((bus.i_weight_layer == L_H1) && addr_match_c) begin
            we_h1_c = 1'b1;
            if (exp_addr == LAST_H1) begin
              state_n    = ST_RX_H2;
              exp_addr_n = '0;
            end else begin
              exp_addr_n = exp_addr + AW'(1);
            end
          end else begin
            state_n = ST_ERR;
          end
        end
        ST_RX_H2: begin
          if ((bus.i_weight_layer == L_H2) && addr_match_c) begin
            we_h2_c = 1'b1;
            if (exp_addr == LAST_H2) begin
              state_n    = ST_RX_OUT;
              exp_addr_n = '0;
            end else begin
              exp_addr_n = exp_addr + AW'(1);
            end
          end else begin
            state_n = ST_ERR;
          end
        end
        ST_RX_OUT: begin
          if ((bus.i_weight_layer == L_OUT) && addr_match_c) begin
            we_out_c = 1'b1;
            if (exp_addr == LAST_OUT) begin
              state_n    = ST_DONE;
              exp_addr_n = '0;
            end else begin
              exp_addr_n = exp_addr + AW'(1);
            end
          end else begin
            state_n = ST_ERR;
          end
        end
        ST_ERR: begin
          state_n = ST_ERR;
        end
        default: begin
          state_n    = ST_IDLE;
          exp_addr_n = '0;
        end
      endcase
    end

    busy_n  = (state_n == ST_RX_H1) || (state_n == ST_RX_H2) || (state_n == ST_RX_OUT);
    done_n  = (state_n == ST_DONE);
    error_n = (state_n == ST_ERR);
  end

  // Readback decode: only in-range addresses of a real layer hit a RAM.
  assign rd_hit_h1_c  = bus.i_rd_en && (bus.i_rd_layer == L_H1)  && (bus.i_rd_addr < AW'(SIZE_H1));
  assign rd_hit_h2_c  = bus.i_rd_en && (bus.i_rd_layer == L_H2)  && (bus.i_rd_addr < AW'(SIZE_H2));
  assign rd_hit_out_c = bus.i_rd_en && (bus.i_rd_layer == L_OUT) && (bus.i_rd_addr < AW'(SIZE_OUT));

  // Readback pipeline: remember which RAM (if any) answers next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= L_NONE;
    end else begin
      rd_valid_q <= bus.i_rd_en;
      if (rd_hit_h1_c) begin
        rd_sel_q <= L_H1;
      end else if (rd_hit_h2_c) begin
        rd_sel_q <= L_H2;
      end else if (rd_hit_out_c) begin
        rd_sel_q <= L_OUT;
      end else begin
        rd_sel_q <= L_NONE;
      end
    end
  end

  weight_ram #(.DEPTH(SIZE_H1), .WIDTH(DATA_WIDTH)) u_ram_h1 (
    .clk   (clk),
    .we    (we_h1_c),
    .waddr (AW_H1'(bus.i_weight_addr)),
    .wdata (bus.i_weight),
    .re    (rd_hit_h1_c),
    .raddr (AW_H1'(bus.i_rd_addr)),
    .rdata (rdata_h1)
  );

  weight_ram #(.DEPTH(SIZE_H2), .WIDTH(DATA_WIDTH)) u_ram_h2 (
    .clk   (clk),
    .we    (we_h2_c),
    .waddr (AW_H2'(bus.i_weight_addr)),
    .wdata (bus.i_weight),
    .re    (rd_hit_h2_c),
    .raddr (AW_H2'(bus.i_rd_addr)),
    .rdata (rdata_h2)
  );

  weight_ram #(.DEPTH(SIZE_OUT), .WIDTH(DATA_WIDTH)) u_ram_out (
    .clk   (clk),
    .we    (we_out_c),
    .waddr (AW_OUT'(bus.i_weight_addr)),
    .wdata (bus.i_weight),
    .re    (rd_hit_out_c),
    .raddr (AW_OUT'(bus.i_rd_addr)),
    .rdata (rdata_out)
  );

  // Readback mux; misses (layer 00 / out of range) return zero.
  always_comb begin
    rd_data_c = '0;
    case (rd_sel_q)
      L_H1:    rd_data_c = rdata_h1;
      L_H2:    rd_data_c = rdata_h2;
      L_OUT:   rd_data_c = rdata_out;
      default: rd_data_c = '0;
    endcase
  end

  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data   = rd_data_c;
  assign bus.o_busy      = busy_q;
  assign bus.o_load_done = done_q;
  assign bus.o_error     = error_q;

endmodule

// File: tb/tb_weight_stream_receiver.sv
// Self-checking bench for weight_stream_receiver: a reference RAM model
// feeds a queue of expected readback words that a monitor pops on every
// o_rd_valid; status flags are checked directly after each scenario.
module tb_weight_stream_receiver;
  import weight_stream_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 2;
  localparam int unsigned AW  = 11;
  localparam int unsigned NS1 = N1;
  localparam int unsigned NS2 = N2;
  localparam int unsigned NS3 = N3;

  typedef struct {
    logic [1:0]  l;
    logic [10:0] a;
    logic [31:0] d;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  weight_stream_receiver_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(LW), .WEIGHT_COUNTER_WIDTH(AW)) bus ();

  weight_stream_receiver #(
    .DATA_WIDTH(DW), .LAYER_WIDTH(LW), .WEIGHT_COUNTER_WIDTH(AW),
    .NUMBER_OF_INPUT_NODE(2), .NUMBER_OF_HIDDEN_NODE_LAYER_1(32),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(32), .NUMBER_OF_OUTPUT_NODE(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] m1 [NS1];
  logic [31:0] m2 [NS2];
  logic [31:0] m3 [NS3];
  rd_exp_t     exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int unsigned seed, input logic [1:0] l, input logic [10:0] a);
    return (32'(seed) * 32'h9E37_79B9) ^ (32'(l) << 12) ^ 32'(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] l, input logic [10:0] a);
    case (l)
      2'b01:   return (32'(a) < NS1) ? m1[a] : 32'h0;
      2'b10:   return (32'(a) < NS2) ? m2[a] : 32'h0;
      2'b11:   return (32'(a) < NS3) ? m3[a] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_wr(input logic [1:0] l, input logic [10:0] a, input logic [31:0] d);
    case (l)
      2'b01:   m1[a] = d;
      2'b10:   m2[a] = d;
      2'b11:   m3[a] = d;
      default: ;
    endcase
  endtask

  // Readback monitor: every response must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_n && bus.o_rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_spurious", 32'(bus.o_rd_valid), 32'h0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check_eq($sformatf("rd_%0d_%0d", e.l, e.a), bus.o_rd_data, e.d);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.i_weight_valid = 1'b0;
    bus.i_rd_en        = 1'b0;
    bus.i_clear        = 1'b0;
  endtask

  task automatic drive_word(input logic [1:0] l, input logic [10:0] a, input logic [31:0] d);
    bus.i_weight_valid = 1'b1;
    bus.i_weight_layer = l;
    bus.i_weight_addr  = a;
    bus.i_weight       = d;
  endtask

  task automatic issue_rd(input logic [1:0] l, input logic [10:0] a, input logic [31:0] d);
    rd_exp_t e;
    bus.i_rd_en    = 1'b1;
    bus.i_rd_layer = l;
    bus.i_rd_addr  = a;
    e.l = l; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done, input logic err);
    check_eq({tag, "_busy"}, 32'(bus.o_busy), 32'(busy));
    check_eq({tag, "_done"}, 32'(bus.o_load_done), 32'(done));
    check_eq({tag, "_error"}, 32'(bus.o_error), 32'(err));
  endtask

  task automatic send_range(input int unsigned seed, input logic [1:0] l, input int lo, input int hi,
                            input int unsigned gapmax);
    logic [31:0] d;
    for (int a = lo; a <= hi; a++) begin
      if (l == 2'b11 && a == int'(NS3) - 1) check_eq("done_before_last", 32'(bus.o_load_done), 32'h0);
      d = gen(seed, l, 11'(a));
      model_wr(l, 11'(a), d);
      drive_word(l, 11'(a), d);
      tick();
      repeat ($urandom_range(gapmax, 0)) tick();
    end
  endtask

  task automatic send_stream(input int unsigned seed, input int unsigned gapmax);
    send_range(seed, 2'b01, 0, int'(NS1) - 1, gapmax);
    check_status("h2_start", 1'b1, 1'b0, 1'b0);
    send_range(seed, 2'b10, 0, int'(NS2) - 1, gapmax);
    send_range(seed, 2'b11, 0, int'(NS3) - 1, gapmax);
    check_status("stream_done", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic read_all();
    for (int l = 1; l <= 3; l++) begin
      int n;
      n = (l == 1) ? int'(NS1) : (l == 2) ? int'(NS2) : int'(NS3);
      for (int a = 0; a < n; a++) begin
        issue_rd(2'(l), 11'(a), model_rd(2'(l), 11'(a)));
        tick();
      end
    end
    tick();
    tick();
    check_eq("rd_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n              = 1'b0;
    bus.i_weight_valid = 1'b0;
    bus.i_weight_layer = '0;
    bus.i_weight_addr  = '0;
    bus.i_weight       = '0;
    bus.i_clear        = 1'b0;
    bus.i_rd_en        = 1'b0;
    bus.i_rd_layer     = '0;
    bus.i_rd_addr      = '0;
    repeat (2) @(negedge clk);
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset_rd_valid", 32'(bus.o_rd_valid), 32'h0);
    check_eq("reset_rd_data", bus.o_rd_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back stream, then targeted and full readback
    send_stream(1, 0);
    issue_rd(2'b10, 11'd33, gen(1, 2'b10, 11'd33));
    tick();
    tick();
    read_all();

    // 2: same stream with random gaps
    send_stream(1, 5);
    read_all();

    // 5: restart from DONE with new values; same-cycle read returns old data
    d = gen(5, 2'b01, 11'd0);
    drive_word(2'b01, 11'd0, d);
    issue_rd(2'b01, 11'd0, model_rd(2'b01, 11'd0));
    model_wr(2'b01, 11'd0, d);
    tick();
    check_status("restart", 1'b1, 1'b0, 1'b0);
    send_range(5, 2'b01, 1, int'(NS1) - 1, 0);
    send_range(5, 2'b10, 0, int'(NS2) - 1, 2);
    send_range(5, 2'b11, 0, int'(NS3) - 1, 0);
    check_status("reload_done", 1'b0, 1'b1, 1'b0);
    read_all();

    // 3: duplicate hidden-1 addr 5 is an order violation
    send_range(7, 2'b01, 0, 5, 0);
    check_status("partial", 1'b1, 1'b0, 1'b0);
    drive_word(2'b01, 11'd5, 32'hDEAD_BEEF);
    tick();
    check_status("dup_addr", 1'b0, 1'b0, 1'b1);
    drive_word(2'b01, 11'd6, gen(7, 2'b01, 11'd6));
    tick();
    drive_word(2'b01, 11'd7, gen(7, 2'b01, 11'd7));
    tick();
    check_status("err_sticky", 1'b0, 1'b0, 1'b1);
    issue_rd(2'b01, 11'd5, model_rd(2'b01, 11'd5));
    tick();
    issue_rd(2'b01, 11'd6, model_rd(2'b01, 11'd6));
    tick();
    tick();
    bus.i_clear = 1'b1;
    tick();
    check_status("cleared", 1'b0, 1'b0, 1'b0);

    // layer 00 mid-load is a violation
    send_range(8, 2'b01, 0, 0, 0);
    drive_word(2'b00, 11'd1, 32'h0BAD_0000);
    tick();
    check_status("layer0", 1'b0, 1'b0, 1'b1);
    bus.i_clear = 1'b1;
    tick();

    // 4: stream starting at hidden-2 from IDLE
    drive_word(2'b10, 11'd0, 32'h2222_0000);
    tick();
    check_status("bad_start", 1'b0, 1'b0, 1'b1);
    bus.i_clear = 1'b1;
    tick();
    check_status("clear_idle", 1'b0, 1'b0, 1'b0);
    // clear wins over a simultaneous valid word
    drive_word(2'b01, 11'd0, 32'h1234_5678);
    bus.i_clear = 1'b1;
    tick();
    check_status("clear_prio", 1'b0, 1'b0, 1'b0);
    issue_rd(2'b01, 11'd0, model_rd(2'b01, 11'd0));
    tick();
    send_range(9, 2'b01, 0, 0, 0);
    check_status("idle_accept", 1'b1, 1'b0, 1'b0);
    bus.i_clear = 1'b1;
    tick();
    // out-of-range and layer-00 reads return zero
    issue_rd(2'b00, 11'd5, 32'h0);
    tick();
    issue_rd(2'b01, 11'(NS1), 32'h0);
    tick();
    tick();

    // 6: async reset in the middle of hidden-2
    send_range(11, 2'b01, 0, int'(NS1) - 1, 0);
    send_range(11, 2'b10, 0, 400, 0);
    rst_n = 1'b0;
    #1;
    check_status("mid_reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    drive_word(2'b10, 11'd401, gen(11, 2'b10, 11'd401));
    tick();
    check_status("resume_rejected", 1'b0, 1'b0, 1'b1);
    bus.i_clear = 1'b1;
    tick();
    send_stream(12, 1);
    issue_rd(2'b11, 11'd99, 32'h0);
    tick();
    tick();
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
